// File: rtl/av2_recon_pkg.sv
// Shared definitions for the reconstructed-frame packer.
//   state_t     : frame sequencer states
//   DATA_W      : width of one output beat in bits
//   PPB_8/16    : pixels per beat for 8-bit packing and 16-bit containers
//   MODE_*      : pack_mode encodings
package av2_recon_pkg;

  localparam int DATA_W = 128;
  localparam int PPB_8  = 16;
  localparam int PPB_16 = 8;

  localparam logic MODE_8BIT  = 1'b0;
  localparam logic MODE_16BIT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PACK,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/av2_pixel_round_sat.sv
// Converts one reconstructed sample to 8 bits with round-half-up and
// saturation at 255. An 8-bit sample passes straight through.
//   pix  : input sample, PIXEL_WIDTH bits
//   pix8 : rounded and saturated 8-bit sample
module av2_pixel_round_sat #(
  parameter int PIXEL_WIDTH = 10
) (
  input  logic [PIXEL_WIDTH-1:0] pix,
  output logic [7:0]             pix8
);

  generate
    if (PIXEL_WIDTH == 8) begin : g_pass
      assign pix8 = pix;
    end else begin : g_round
      // One extra bit so the rounding add cannot wrap.
      localparam logic [PIXEL_WIDTH:0] HALF = (PIXEL_WIDTH+1)'(1) << (PIXEL_WIDTH - 9);
      localparam logic [PIXEL_WIDTH:0] SAT  = (PIXEL_WIDTH+1)'(255);
      logic [PIXEL_WIDTH:0] sum;
      logic [PIXEL_WIDTH:0] shifted;
      assign sum     = {1'b0, pix} + HALF;
      assign shifted = sum >> (PIXEL_WIDTH - 8);
      assign pix8    = (shifted > SAT) ? 8'hFF : shifted[7:0];
    end
  endgenerate

endmodule

// File: rtl/av2_recon_packer.sv
// Packs raster-order reconstructed samples into 128-bit beats with byte
// addresses. Beats close when full or at the end of a row; a row-final beat
// has its unused lanes zeroed. An assembly register feeds one output register.
//   clk, rst_n                     : clock, synchronous active-low reset
//   start, frame_width/height,
//   pack_mode                      : frame setup, latched on start in IDLE
//   pix_data, pix_valid, pix_ready : sample input handshake
//   recon_data, recon_addr,
//   recon_wr_en, recon_ready       : beat output handshake
//   busy, frame_done               : frame status
module av2_recon_packer
  import av2_recon_pkg::*;
#(
  parameter int PIXEL_WIDTH = 10,
  parameter int MAX_WIDTH   = 64,
  parameter int MAX_HEIGHT  = 64,
  parameter int ADDR_W      = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [15:0]            frame_width,
  input  logic [15:0]            frame_height,
  input  logic                   pack_mode,
  input  logic [PIXEL_WIDTH-1:0] pix_data,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  output logic [DATA_W-1:0]      recon_data,
  output logic [ADDR_W-1:0]      recon_addr,
  output logic                   recon_wr_en,
  input  logic                   recon_ready,
  output logic                   busy,
  output logic                   frame_done
);

  state_t              state_reg;
  logic                launch_reg;      // setup latched, decide PACK/DONE next
  logic [15:0]         width_reg, height_reg;
  logic                mode_reg;
  logic [15:0]         col_reg, row_reg;
  logic [3:0]          lane_reg;
  logic [ADDR_W-1:0]   addr_reg;        // address of the beat being assembled
  logic [DATA_W-1:0]   asm_data_reg;
  logic [ADDR_W-1:0]   asm_addr_reg;
  logic                asm_closed_reg;  // assembly holds a finished beat
  logic [DATA_W-1:0]   out_data_reg;
  logic [ADDR_W-1:0]   out_addr_reg;
  logic                out_valid_reg;
  logic                frame_done_reg;

  logic [7:0]          pix8;
  logic                out_free, accept, row_end, frame_end, lane_full, close_now;
  logic [15:0]         lane_val, clamp_w, clamp_h;
  logic [6:0]          shift;
  logic [DATA_W-1:0]   asm_base, beat_next;

  av2_pixel_round_sat #(.PIXEL_WIDTH(PIXEL_WIDTH)) u_round (
    .pix  (pix_data),
    .pix8 (pix8)
  );

  always_comb begin
    clamp_w   = (frame_width  > 16'(MAX_WIDTH))  ? 16'(MAX_WIDTH)  : frame_width;
    clamp_h   = (frame_height > 16'(MAX_HEIGHT)) ? 16'(MAX_HEIGHT) : frame_height;
    // Output register can take a beat this cycle if empty or being accepted.
    out_free  = !out_valid_reg || recon_ready;
    pix_ready = (state_reg == ST_PACK) && (!asm_closed_reg || out_free);
    accept    = pix_valid && pix_ready;
    row_end   = (col_reg == width_reg - 16'd1);
    frame_end = row_end && (row_reg == height_reg - 16'd1);
    lane_full = (mode_reg == MODE_16BIT) ? (lane_reg == 4'(PPB_16 - 1))
                                         : (lane_reg == 4'(PPB_8 - 1));
    close_now = row_end || lane_full;
    lane_val  = (mode_reg == MODE_16BIT) ? 16'(pix_data) : {8'd0, pix8};
    shift     = (mode_reg == MODE_16BIT) ? {lane_reg[2:0], 4'd0} : {lane_reg, 3'd0};
    // A closed beat leaves assembly whenever a new pixel is accepted, so the
    // new pixel always starts from an empty beat in that case.
    asm_base  = asm_closed_reg ? '0 : asm_data_reg;
    beat_next = asm_base | (DATA_W'(lane_val) << shift);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      launch_reg     <= 1'b0;
      width_reg      <= '0;
      height_reg     <= '0;
      mode_reg       <= MODE_8BIT;
      col_reg        <= '0;
      row_reg        <= '0;
      lane_reg       <= '0;
      addr_reg       <= '0;
      asm_data_reg   <= '0;
      asm_addr_reg   <= '0;
      asm_closed_reg <= 1'b0;
      out_data_reg   <= '0;
      out_addr_reg   <= '0;
      out_valid_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;

      if (out_valid_reg && recon_ready)
        out_valid_reg <= 1'b0;

      if (asm_closed_reg && out_free) begin
        out_data_reg   <= asm_data_reg;
        out_addr_reg   <= asm_addr_reg;
        out_valid_reg  <= 1'b1;
        asm_closed_reg <= 1'b0;
      end

      if (accept) begin
        if (close_now) begin
          lane_reg <= '0;
          addr_reg <= addr_reg + ADDR_W'(16);
          if (!asm_closed_reg && out_free) begin
            // Straight to the output register: wr_en rises next cycle.
            out_data_reg  <= beat_next;
            out_addr_reg  <= addr_reg;
            out_valid_reg <= 1'b1;
            asm_data_reg  <= '0;
          end else begin
            asm_data_reg   <= beat_next;
            asm_addr_reg   <= addr_reg;
            asm_closed_reg <= 1'b1;
          end
        end else begin
          asm_data_reg <= beat_next;
          lane_reg     <= lane_reg + 4'd1;
        end
        if (row_end) begin
          col_reg <= '0;
          row_reg <= row_reg + 16'd1;
        end else begin
          col_reg <= col_reg + 16'd1;
        end
      end

      case (state_reg)
        ST_IDLE: begin
          if (launch_reg) begin
            launch_reg <= 1'b0;
            if (width_reg == 16'd0 || height_reg == 16'd0) begin
              state_reg      <= ST_DONE;
              frame_done_reg <= 1'b1;
            end else begin
              state_reg <= ST_PACK;
            end
          end else if (start) begin
            width_reg    <= clamp_w;
            height_reg   <= clamp_h;
            mode_reg     <= pack_mode;
            launch_reg   <= 1'b1;
            col_reg      <= '0;
            row_reg      <= '0;
            lane_reg     <= '0;
            addr_reg     <= '0;
            asm_data_reg <= '0;
          end
        end
        ST_PACK: begin
          if (accept && frame_end)
            state_reg <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!asm_closed_reg && out_free) begin
            state_reg      <= ST_DONE;
            frame_done_reg <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign recon_data  = out_data_reg;
  assign recon_addr  = out_addr_reg;
  assign recon_wr_en = out_valid_reg;
  assign busy        = (state_reg == ST_PACK) || (state_reg == ST_DRAIN);
  assign frame_done  = frame_done_reg;

endmodule

// File: tb/tb_av2_recon_packer.sv
module tb_av2_recon_packer;

  localparam int PW = 10;

  typedef struct {
    logic [31:0]  addr;
    logic [127:0] data;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   frame_width = '0;
  logic [15:0]   frame_height = '0;
  logic          pack_mode = 1'b0;
  logic [PW-1:0] pix_data = '0;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  logic [127:0]  recon_data;
  logic [31:0]   recon_addr;
  logic          recon_wr_en;
  logic          recon_ready = 1'b1;
  logic          busy;
  logic          frame_done;

  av2_recon_packer #(
    .PIXEL_WIDTH(PW), .MAX_WIDTH(64), .MAX_HEIGHT(64), .ADDR_W(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .frame_width(frame_width), .frame_height(frame_height), .pack_mode(pack_mode),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .recon_data(recon_data), .recon_addr(recon_addr), .recon_wr_en(recon_wr_en),
    .recon_ready(recon_ready), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int beats_seen = 0;
  int wr_seen = 0;
  int done_count = 0;
  int last_xfer_cyc = 0;
  int ready_mode = 0;
  beat_t exp_q[$];
  beat_t mon_e;
  logic [PW-1:0] pix_mem [0:4095];
  logic          stall_prev = 1'b0;
  logic [127:0]  held_data = '0;
  logic [31:0]   held_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Sink readiness: always ready, or ready one cycle in three.
  initial forever begin
    @(posedge clk);
    #1;
    recon_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
  end

  // Scoreboard: every accepted beat is popped and compared; stalled beats
  // must hold their data and address.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (recon_wr_en) wr_seen++;
      if (frame_done) done_count++;
      if (stall_prev) begin
        total++;
        if (!recon_wr_en || recon_data !== held_data || recon_addr !== held_addr) begin
          bad++;
          $display("FAIL stall_hold: wr_en=%0b addr=%0h data=%h required wr_en=1 addr=%0h data=%h",
                   recon_wr_en, recon_addr, recon_data, held_addr, held_data);
        end
      end
      if (recon_wr_en && recon_ready) begin
        beats_seen++;
        last_xfer_cyc = cyc;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL beat_unexpected: addr=%0h data=%h required no beat", recon_addr, recon_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (recon_addr !== mon_e.addr || recon_data !== mon_e.data) begin
            bad++;
            $display("FAIL beat: addr=%0h data=%h required addr=%0h data=%h",
                     recon_addr, recon_data, mon_e.addr, mon_e.data);
          end else begin
            $display("beat addr=%0h data=%h ok", recon_addr, recon_data);
          end
        end
      end
      stall_prev = recon_wr_en && !recon_ready;
      held_data  = recon_data;
      held_addr  = recon_addr;
    end
  end

  function automatic logic [7:0] conv8(input logic [PW-1:0] p);
    int v;
    v = (int'(p) + 2) / 4;
    return (v > 255) ? 8'hFF : 8'(v);
  endfunction

  // Reference packing: beat (r, bi) lives at 16 * (r * bpr + bi).
  task automatic build_expected(input int w, input int h, input logic mode);
    int cw, ch, ppb, bpr, c;
    beat_t b;
    cw  = (w > 64) ? 64 : w;
    ch  = (h > 64) ? 64 : h;
    ppb = mode ? 8 : 16;
    bpr = (cw + ppb - 1) / ppb;
    for (int r = 0; r < ch; r++) begin
      for (int bi = 0; bi < bpr; bi++) begin
        b.addr = 32'(16 * (r * bpr + bi));
        b.data = '0;
        for (int l = 0; l < ppb; l++) begin
          c = bi * ppb + l;
          if (c < cw) begin
            if (mode) b.data[l*16 +: 16] = 16'(pix_mem[r*cw + c]);
            else      b.data[l*8 +: 8]   = conv8(pix_mem[r*cw + c]);
          end
        end
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic drive_frame(input int w, input int h, input logic mode, input int n_pix,
                             input bit gaps, input bit inject_start, output int acc_cyc);
    logic acc;
    int   guard;
    acc_cyc = -1;
    @(posedge clk); #1;
    frame_width = 16'(w); frame_height = 16'(h); pack_mode = mode; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < n_pix; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        pix_valid = 1'b0;
        @(posedge clk); #1;
      end
      if (inject_start && i == n_pix / 2) begin
        start = 1'b1;
        frame_width = 16'd5;
      end
      pix_data  = pix_mem[i];
      pix_valid = 1'b1;
      acc   = 1'b0;
      guard = 0;
      while (!acc && guard < 1000) begin
        @(negedge clk);
        acc = pix_ready;
        if (acc) acc_cyc = cyc;
        @(posedge clk); #1;
        guard++;
      end
      start = 1'b0;
      if (!acc) begin
        total++; bad++;
        $display("FAIL pix_accept_timeout: pixel %0d not accepted, required accept within 1000 cycles", i);
        pix_valid = 1'b0;
        return;
      end
    end
    pix_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int seen);
    seen = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (frame_done) begin
        seen = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({pix_ready, recon_wr_en, busy, frame_done} !== 4'b0 || recon_data !== '0 || recon_addr !== '0) begin
      bad++;
      $display("FAIL reset_state: rdy=%0b wr=%0b busy=%0b done=%0b addr=%0h data=%h required all zero",
               pix_ready, recon_wr_en, busy, frame_done, recon_addr, recon_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_full_frame();
    int seen, acc_cyc, d0, b0;
    for (int i = 0; i < 4096; i++) pix_mem[i] = 10'd512;
    build_expected(64, 64, 1'b0);
    d0 = done_count; b0 = beats_seen;
    drive_frame(64, 64, 1'b0, 4096, 1'b0, 1'b0, acc_cyc);
    @(negedge clk);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL full_busy: busy=%0b required 1", busy); end
    wait_done(200, seen);
    total++;
    if (seen != last_xfer_cyc + 1) begin
      bad++; $display("FAIL full_done_timing: done_cyc=%0d required %0d", seen, last_xfer_cyc + 1);
    end
    @(negedge clk);
    total++;
    if (frame_done !== 1'b0) begin bad++; $display("FAIL full_done_width: frame_done=%0b required 0", frame_done); end
    total++;
    if (beats_seen - b0 != 256 || exp_q.size() != 0 || done_count - d0 != 1) begin
      bad++; $display("FAIL full_counts: beats=%0d left=%0d dones=%0d required 256 0 1",
                      beats_seen - b0, exp_q.size(), done_count - d0);
    end
  endtask

  task automatic test_partial_rows();
    int seen, acc_cyc, b0;
    for (int i = 0; i < 40; i++) pix_mem[i] = PW'($urandom_range(8, 1023));
    build_expected(20, 2, 1'b0);
    b0 = beats_seen;
    drive_frame(20, 2, 1'b0, 40, 1'b0, 1'b1, acc_cyc);
    wait_done(100, seen);
    total++;
    if (seen < 0 || beats_seen - b0 != 4 || exp_q.size() != 0) begin
      bad++; $display("FAIL partial_rows: done_cyc=%0d beats=%0d left=%0d required done 4 0",
                      seen, beats_seen - b0, exp_q.size());
    end
  endtask

  task automatic test_mode16();
    int seen, acc_cyc, b0;
    for (int i = 0; i < 8; i++) pix_mem[i] = 10'h3FF;
    build_expected(8, 1, 1'b1);
    b0 = beats_seen;
    drive_frame(8, 1, 1'b1, 8, 1'b0, 1'b0, acc_cyc);
    wait_done(100, seen);
    total++;
    if (seen < 0 || beats_seen - b0 != 1 || exp_q.size() != 0) begin
      bad++; $display("FAIL mode16: done_cyc=%0d beats=%0d left=%0d required done 1 0",
                      seen, beats_seen - b0, exp_q.size());
    end
  endtask

  task automatic test_saturate();
    int seen, acc_cyc;
    int vals[16] = '{1023, 1022, 1021, 1020, 0, 1, 2, 3, 509, 510, 511, 512, 254, 255, 256, 257};
    for (int i = 0; i < 16; i++) pix_mem[i] = PW'(vals[i]);
    build_expected(16, 1, 1'b0);
    drive_frame(16, 1, 1'b0, 16, 1'b0, 1'b0, acc_cyc);
    wait_done(100, seen);
    total++;
    if (last_xfer_cyc != acc_cyc + 1) begin
      bad++; $display("FAIL beat_latency: wr_cyc=%0d required %0d", last_xfer_cyc, acc_cyc + 1);
    end
    total++;
    if (seen < 0 || exp_q.size() != 0) begin
      bad++; $display("FAIL saturate: done_cyc=%0d left=%0d required done 0", seen, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int seen, acc_cyc, b0;
    for (int i = 0; i < 4096; i++) pix_mem[i] = PW'($urandom_range(0, 1023));
    build_expected(64, 64, 1'b1);
    b0 = beats_seen;
    ready_mode = 1;
    drive_frame(64, 64, 1'b1, 4096, 1'b1, 1'b0, acc_cyc);
    wait_done(400, seen);
    ready_mode = 0;
    total++;
    if (seen < 0 || beats_seen - b0 != 512 || exp_q.size() != 0) begin
      bad++; $display("FAIL backpressure: done_cyc=%0d beats=%0d left=%0d required done 512 0",
                      seen, beats_seen - b0, exp_q.size());
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_midframe();
    int seen, acc_cyc, d0, b0;
    for (int i = 0; i < 4096; i++) pix_mem[i] = PW'($urandom_range(0, 1023));
    build_expected(64, 64, 1'b0);
    drive_frame(64, 64, 1'b0, 100, 1'b0, 1'b0, acc_cyc);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({pix_ready, recon_wr_en, busy, frame_done} !== 4'b0 || recon_addr !== '0) begin
      bad++; $display("FAIL midframe_reset_state: rdy=%0b wr=%0b busy=%0b done=%0b addr=%0h required all zero",
                      pix_ready, recon_wr_en, busy, frame_done, recon_addr);
    end
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    d0 = done_count; b0 = beats_seen;
    for (int i = 0; i < 16; i++) pix_mem[i] = PW'($urandom_range(0, 1023));
    build_expected(16, 1, 1'b0);
    drive_frame(16, 1, 1'b0, 16, 1'b0, 1'b0, acc_cyc);
    wait_done(100, seen);
    repeat (3) @(negedge clk);
    total++;
    if (seen < 0 || beats_seen - b0 != 1 || exp_q.size() != 0 || done_count - d0 != 1) begin
      bad++; $display("FAIL after_reset_frame: done_cyc=%0d beats=%0d left=%0d dones=%0d required done 1 0 1",
                      seen, beats_seen - b0, exp_q.size(), done_count - d0);
    end
  endtask

  task automatic test_zero_size();
    int s, seen, w0, d0;
    w0 = wr_seen; d0 = done_count;
    @(posedge clk); #1;
    frame_width = 16'd0; frame_height = 16'd4; pack_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(20, seen);
    total++;
    if (seen != s + 2) begin
      bad++; $display("FAIL zero_done_timing: done_cyc=%0d required %0d", seen, s + 2);
    end
    repeat (5) @(negedge clk);
    total++;
    if (wr_seen != w0 || done_count - d0 != 1) begin
      bad++; $display("FAIL zero_size: wr_cycles=%0d dones=%0d required 0 1", wr_seen - w0, done_count - d0);
    end
  endtask

  task automatic test_clamp();
    int seen, acc_cyc, b0;
    for (int i = 0; i < 64; i++) pix_mem[i] = PW'($urandom_range(0, 1023));
    build_expected(100, 1, 1'b0);
    b0 = beats_seen;
    drive_frame(100, 1, 1'b0, 64, 1'b0, 1'b0, acc_cyc);
    wait_done(100, seen);
    total++;
    if (seen < 0 || beats_seen - b0 != 4 || exp_q.size() != 0) begin
      bad++; $display("FAIL clamp_width: done_cyc=%0d beats=%0d left=%0d required done 4 0",
                      seen, beats_seen - b0, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_partial_rows();
    test_mode16();
    test_saturate();
    test_backpressure();
    test_reset_midframe();
    test_zero_size();
    test_clamp();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
